ip_ppi: RTL and testbench

//  Simplified i8255 PPI clone for the MSX body on the internal MSX-50BUS. I/O ports A8h-ABh only:

---
 rtl/ip_ppi_pkg.sv | 15 +
 rtl/ip_ppi.sv | 83 ++++++++
 tb/tb_ip_ppi.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ip_ppi_pkg.sv
// ip_ppi_pkg: port addresses, Port C bit positions and reset values for the MSX PPI
package ip_ppi_pkg;
    localparam logic [7:0] PPI_PORT_A = 8'hA8;
    localparam logic [7:0] PPI_PORT_B = 8'hA9;
    localparam logic [7:0] PPI_PORT_C = 8'hAA;
    localparam logic [7:0] PPI_CTRL   = 8'hAB;
    localparam int PC_ROW_LSB = 0;
    localparam int PC_MOTOR   = 4;
    localparam int PC_CASW    = 5;
    localparam int PC_CAPS    = 6;
    localparam int PC_CLICK   = 7;
    localparam logic [7:0] PORT_A_RESET    = 8'h00;
    localparam logic [7:0] PORT_C_RESET    = 8'h00;
    localparam logic [7:0] CTRL_READ_VALUE = 8'hFF;
endpackage

// File: rtl/ip_ppi.sv
// ip_ppi: fixed-configuration MSX PPI on I/O ports A8h-ABh; optional PPI_BIT_SET_RESET_EN enables Port C bit set/reset via ABh
module ip_ppi
    import ip_ppi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_address,
    output logic        bus_io_cs,
    output logic        bus_memory_cs,
    output logic        bus_read_ready,
    output logic [7:0]  bus_read_data,
    input  logic [7:0]  bus_write_data,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic        bus_io,
    input  logic        bus_memory,
    output logic [7:0]  primary_slot,
    output logic [3:0]  key_matrix_row,
    output logic        motor_off,
    output logic        cas_write,
    output logic        caps_led_off,
    output logic        click_sound,
    input  logic [7:0]  key_matrix_column
);
    logic       io_hit;
    logic       rd_hit;
    logic       wr_hit;
    logic [7:0] port_a;
    logic [7:0] port_c;
    logic [7:0] rd_mux;
    logic [7:0] rdata;
    logic       ready;

    assign bus_io_cs     = 1'b1;
    assign bus_memory_cs = 1'b0;
    assign io_hit = bus_io && (bus_address[7:2] == PPI_PORT_A[7:2]);
    assign rd_hit = bus_read && io_hit;
    assign wr_hit = bus_write && io_hit;

    assign primary_slot   = port_a;
    assign key_matrix_row = port_c[PC_ROW_LSB +: 4];
    assign motor_off      = port_c[PC_MOTOR];
    assign cas_write      = port_c[PC_CASW];
    assign caps_led_off   = port_c[PC_CAPS];
    assign click_sound    = port_c[PC_CLICK];

    // reset masks the strobe immediately so a pending pulse never reaches the bus
    assign bus_read_ready = ready && !reset;
    assign bus_read_data  = bus_read_ready ? rdata : 8'h00;

    // select read source from the pre-write register values
    always_comb begin
        rd_mux = bus_address[7:0] == PPI_PORT_A ? port_a :
                 bus_address[7:0] == PPI_PORT_B ? key_matrix_column :
                 bus_address[7:0] == PPI_PORT_C ? port_c : CTRL_READ_VALUE;
    end

    // port registers updated by decoded I/O writes
    always_ff @(posedge clk) begin
        if (reset) begin
            port_a <= PORT_A_RESET;
            port_c <= PORT_C_RESET;
        end else if (wr_hit) begin
            if (bus_address[7:0] == PPI_PORT_A) port_a <= bus_write_data;
            if (bus_address[7:0] == PPI_PORT_C) port_c <= bus_write_data;
`ifdef PPI_BIT_SET_RESET_EN
            if (bus_address[7:0] == PPI_CTRL && !bus_write_data[7])
                port_c[bus_write_data[3:1]] <= bus_write_data[0];
`endif
        end
    end

    // one-cycle read strobe with data captured at the request edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= 8'h00;
        end else begin
            ready <= rd_hit;
            rdata <= rd_hit ? rd_mux : 8'h00;
        end
    end
endmodule

// File: tb/tb_ip_ppi.sv
// tb_ip_ppi: randomized and directed checks of ip_ppi against a register-level model
module tb_ip_ppi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bus_address = 16'h0000;
    logic        bus_io_cs, bus_memory_cs, bus_read_ready;
    logic [7:0]  bus_read_data;
    logic [7:0]  bus_write_data = 8'h00;
    logic        bus_read = 1'b0, bus_write = 1'b0, bus_io = 1'b0, bus_memory = 1'b0;
    logic [7:0]  primary_slot;
    logic [3:0]  key_matrix_row;
    logic        motor_off, cas_write, caps_led_off, click_sound;
    logic [7:0]  key_matrix_column = 8'h00;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] m_a = 8'h00, m_c = 8'h00, m_rd = 8'h00;
    logic       m_rdy = 1'b0;

    ip_ppi dut (
        .clk(clk), .reset(reset), .bus_address(bus_address), .bus_io_cs(bus_io_cs),
        .bus_memory_cs(bus_memory_cs), .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data),
        .bus_write_data(bus_write_data), .bus_read(bus_read), .bus_write(bus_write), .bus_io(bus_io),
        .bus_memory(bus_memory), .primary_slot(primary_slot), .key_matrix_row(key_matrix_row),
        .motor_off(motor_off), .cas_write(cas_write), .caps_led_off(caps_led_off),
        .click_sound(click_sound), .key_matrix_column(key_matrix_column)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] port_c_out();
        return {click_sound, caps_led_off, cas_write, motor_off, key_matrix_row};
    endfunction

    task automatic check_all();
        check("io_cs", bus_io_cs, 1'b1);
        check("mem_cs", bus_memory_cs, 1'b0);
        check("ready", bus_read_ready, m_rdy);
        check("rdata", bus_read_data, m_rd);
        check("slot", primary_slot, m_a);
        check("portc", port_c_out(), m_c);
    endtask

    // one bus cycle: model predicts, DUT is clocked, everything compared
    task automatic step(input logic rd, input logic wr, input logic io, input logic mem,
                        input logic [15:0] a, input logic [7:0] wd, input logic [7:0] col);
        logic hit;
        bus_read = rd; bus_write = wr; bus_io = io; bus_memory = mem;
        bus_address = a; bus_write_data = wd; key_matrix_column = col;
        hit = io && a[7:0] >= 8'hA8 && a[7:0] <= 8'hAB;
        m_rdy = rd && hit;
        case (a[7:0])
            8'hA8:   m_rd = m_a;
            8'hA9:   m_rd = col;
            8'hAA:   m_rd = m_c;
            default: m_rd = 8'hFF;
        endcase
        if (!m_rdy) m_rd = 8'h00;
        if (wr && hit) begin
            if (a[7:0] == 8'hA8) m_a = wd;
            if (a[7:0] == 8'hAA) m_c = wd;
`ifdef PPI_BIT_SET_RESET_EN
            if (a[7:0] == 8'hAB && !wd[7]) m_c[wd[3:1]] = wd[0];
`endif
        end
        @(posedge clk);
        #1;
        bus_read = 1'b0; bus_write = 1'b0; bus_io = 1'b0; bus_memory = 1'b0;
        check_all();
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  lo;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
        check("slot_rst", primary_slot, 8'h00);

        step(0, 1, 1, 0, 16'h00A8, 8'h12, 8'h00);
        check("slot_12", primary_slot, 8'h12);
        step(0, 1, 1, 0, 16'hCDA8, 8'hAB, 8'h00);
        check("slot_ab", primary_slot, 8'hAB);
        step(0, 1, 1, 0, 16'h05AA, 8'h55, 8'h00);
        check("portc_55", port_c_out(), 8'h55);

        step(0, 1, 1, 0, 16'h00A8, 8'hDA, 8'h00);
        step(0, 1, 0, 1, 16'h00A8, 8'h11, 8'h00);
        step(0, 1, 0, 1, 16'hCDA8, 8'h22, 8'h00);
        step(0, 1, 0, 1, 16'hABA8, 8'h33, 8'h00);
        check("slot_mem", primary_slot, 8'hDA);
        step(0, 1, 1, 0, 16'h00AA, 8'hAD, 8'h00);
        step(0, 1, 0, 1, 16'h00AA, 8'h11, 8'h00);
        step(0, 1, 0, 1, 16'hCDAA, 8'h22, 8'h00);
        check("portc_mem", port_c_out(), 8'hAD);

        step(0, 1, 1, 0, 16'h00A8, 8'h12, 8'h9A);
        step(0, 1, 1, 0, 16'h00AA, 8'h56, 8'h9A);
        step(0, 1, 1, 0, 16'h00AB, 8'h78, 8'h9A);
        step(1, 0, 1, 0, 16'h00A8, 8'h00, 8'h9A);
        check("rd_a8", bus_read_data, 8'h12);
        step(1, 0, 1, 0, 16'h56A9, 8'h00, 8'h9A);
        check("rd_a9", bus_read_data, 8'h9A);
`ifndef PPI_BIT_SET_RESET_EN
        step(1, 0, 1, 0, 16'h00AA, 8'h00, 8'h9A);
        check("rd_aa", bus_read_data, 8'h56);
`endif
        step(1, 0, 1, 0, 16'h00AB, 8'h00, 8'h9A);
        check("rd_ab", bus_read_data, 8'hFF);
        step(1, 0, 1, 0, 16'h54A8, 8'h00, 8'h9A);
        check("rd_54a8_rdy", bus_read_ready, 1'b1);
        step(0, 0, 0, 0, 16'h0000, 8'h00, 8'h9A);
        check("rdy_drop", bus_read_ready, 1'b0);

        step(1, 1, 1, 0, 16'h00A8, 8'h3C, 8'h00);
        check("rmw_old", bus_read_data, 8'h12);
        check("rmw_new", primary_slot, 8'h3C);

        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 16'h00A8 + 16'(i), 8'h00, 8'h00);
        step(1, 0, 1, 0, 16'h00A7, 8'h00, 8'h00);
        step(1, 0, 1, 0, 16'h00AC, 8'h00, 8'h00);
        step(1, 0, 1, 0, 16'h0001, 8'h00, 8'h00);
        step(1, 0, 1, 0, 16'h0023, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 16'h0000, 8'h00, 8'h00);

        for (int i = 0; i < 300; i++) begin
            a[15:8] = 8'($urandom);
            lo = ($urandom % 4 == 0) ? 8'($urandom) : 8'hA8 + 8'($urandom % 4);
            a[7:0] = lo;
            step(1'($urandom), 1'($urandom), ($urandom % 4) != 0, 1'($urandom), a,
                 8'($urandom), 8'($urandom));
        end

        bus_read = 1'b1; bus_io = 1'b1; bus_address = 16'h00A8;
        @(posedge clk);
        #1;
        bus_read = 1'b0; bus_io = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_no_rdy", bus_read_ready, 1'b0);
        check("rst_no_data", bus_read_data, 8'h00);
        bus_write = 1'b1; bus_io = 1'b1; bus_address = 16'h00A8; bus_write_data = 8'h77;
        @(posedge clk);
        #1;
        bus_write = 1'b0; bus_io = 1'b0;
        reset = 1'b0;
        m_a = 8'h00; m_c = 8'h00; m_rdy = 1'b0; m_rd = 8'h00;
        check_all();
        check("rst_slot", primary_slot, 8'h00);
        step(0, 0, 0, 0, 16'h0000, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
